// File: rtl/gpio_cfg_pkg.sv
// Shared types and defaults for the GPIO config serial loader:
// FSM state encoding, default chain dimensions, index-width helper.
package gpio_cfg_pkg;

  localparam int CFG_WIDTH_DEF = 13;
  localparam int NUM_PADS_DEF  = 19;
  localparam int CLK_DIV_DEF   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_CAPT,
    S_SHIFT,
    S_LOAD,
    S_FIN
  } state_e;

  // Counter width for n states; never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_serial_loader_if.sv
// Request/fetch/chain signal bundle of the GPIO serial loader.
// master: housekeeping + config store side; slave: the loader.
interface gpio_serial_loader_if
  import gpio_cfg_pkg::*;
#(
  parameter int CFG_WIDTH = CFG_WIDTH_DEF,
  parameter int IDX_W     = idx_w(NUM_PADS_DEF)
) ();

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [IDX_W-1:0]     cfg_idx;
  logic [CFG_WIDTH-1:0] cfg_data;
  logic                 serial_clock;
  logic                 serial_data_out;
  logic                 serial_load;
  logic                 serial_resetn;

  modport master (
    output start, cfg_data,
    input  busy, done, cfg_idx,
    input  serial_clock, serial_data_out,
    input  serial_load, serial_resetn
  );

  modport slave (
    input  start, cfg_data,
    output busy, done, cfg_idx,
    output serial_clock, serial_data_out,
    output serial_load, serial_resetn
  );

endinterface

// File: rtl/serial_bit_timer.sv
// Divides clock into 2*CLK_DIV-cycle bit periods: phase (serial clock),
// half-period strobe and bit-end strobe. Held at zero while en_i is low.
module serial_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  output logic sclk_o,
  output logic half_o,
  output logic bit_end_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          ph_q, ph_d;

  always_comb begin
    div_d = div_q;
    ph_d  = ph_q;
    if (!en_i) begin
      div_d = '0;
      ph_d  = 1'b0;
    end else if (div_q == DIV_MAX) begin
      div_d = '0;
      ph_d  = ~ph_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ph_q  <= ph_d;
    end
  end

  assign half_o    = en_i && (div_q == DIV_MAX);
  assign bit_end_o = half_o && ph_q;
  assign sclk_o    = ph_q;

endmodule

// File: rtl/gpio_serial_loader.sv
// Fetches one config word per pad (highest index first), shifts each out
// MSB first, then strobes load. Ports: clock, reset, bus (slave modport).
module gpio_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS  = NUM_PADS_DEF,
  parameter int CFG_WIDTH = CFG_WIDTH_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int IDX_W     = idx_w(NUM_PADS)
) (
  input logic             clock,
  input logic             reset,
  gpio_serial_loader_if.slave bus
);

  localparam int BW = idx_w(CFG_WIDTH);
  localparam logic [IDX_W-1:0] PAD_TOP = IDX_W'(NUM_PADS - 1);
  localparam logic [BW-1:0]    BIT_TOP = BW'(CFG_WIDTH - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     pad_q, pad_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [CFG_WIDTH-1:0] sh_q, sh_d;
  logic                 tmr_en, sclk_w, half_w, bend_w;

  // CLR and LOAD reuse one bit period of the timer as their duration.
  assign tmr_en = state_q inside {S_CLR, S_SHIFT, S_LOAD};

  serial_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_tmr (
    .clock     (clock),
    .reset     (reset),
    .en_i      (tmr_en),
    .sclk_o    (sclk_w),
    .half_o    (half_w),
    .bit_end_o (bend_w)
  );

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_CLR;
      end
      S_CLR: begin
        if (bend_w) begin
          pad_d   = PAD_TOP;
          idx_d   = PAD_TOP;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CAPT;
      S_CAPT: begin
        sh_d    = bus.cfg_data;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Advance data on the falling edge of serial_clock.
        if (half_w && sclk_w) begin
          sh_d = {sh_q[CFG_WIDTH-2:0], 1'b0};
        end
        if (bend_w) begin
          if (bit_q == BIT_TOP) begin
            bit_d = '0;
            if (pad_q == '0) begin
              state_d = S_LOAD;
            end else begin
              pad_d   = pad_q - 1'b1;
              idx_d   = pad_d;
              state_d = S_FETCH;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bend_w) state_d = S_FIN;
      end
      S_FIN: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pad_q   <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  assign bus.busy    = !(state_q inside {S_IDLE, S_FIN});
  assign bus.done    = (state_q == S_FIN);
  assign bus.cfg_idx = idx_q;
  assign bus.serial_clock    = (state_q == S_SHIFT) && sclk_w;
  assign bus.serial_data_out = (state_q == S_SHIFT) && sh_q[CFG_WIDTH-1];
  assign bus.serial_load     = (state_q == S_LOAD);
  // Chain is held clear during reset as well as in CLR.
  assign bus.serial_resetn   = !reset && (state_q != S_CLR);

endmodule
